// File: rtl/pipe_mem_reg_p.sv
// Execute-to-memory pipeline register with stall/bubble control,
// saturating event counters and a sticky control-conflict flag.
module pipe_mem_reg_p #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned REG_W     = 4,
    parameter int unsigned ICODE_W   = 4,
    parameter int unsigned STAT_W    = 3,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned NOP_ICODE = 1,
    parameter int unsigned RNONE     = 15,
    parameter int unsigned BUB_STAT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               M_stall,
    input  logic               M_bubble,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [STAT_W-1:0]  E_stat,
    input  logic               e_cnd,
    input  logic [DATA_W-1:0]  e_valE,
    input  logic [DATA_W-1:0]  e_valA,
    input  logic [REG_W-1:0]   e_dstE,
    input  logic [REG_W-1:0]   E_dstM,
    output logic [ICODE_W-1:0] M_icode,
    output logic [STAT_W-1:0]  M_stat,
    output logic               M_cnd,
    output logic [DATA_W-1:0]  M_valE,
    output logic [DATA_W-1:0]  M_valA,
    output logic [REG_W-1:0]   M_dstE,
    output logic [REG_W-1:0]   M_dstM,
    output logic               M_valid,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               ctl_err
);

    localparam logic [ICODE_W-1:0] NOP_I  = ICODE_W'(NOP_ICODE);
    localparam logic [REG_W-1:0]   R_NONE = REG_W'(RNONE);
    localparam logic [STAT_W-1:0]  B_STAT = STAT_W'(BUB_STAT);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    // Pipeline payload: bubble beats stall, stall beats load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M_icode <= NOP_I;
            M_stat  <= B_STAT;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= R_NONE;
            M_dstM  <= R_NONE;
            M_valid <= 1'b0;
        end else if (M_bubble) begin
            M_icode <= NOP_I;
            M_stat  <= B_STAT;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= R_NONE;
            M_dstM  <= R_NONE;
            M_valid <= 1'b0;
        end else if (!M_stall) begin
            M_icode <= E_icode;
            M_stat  <= E_stat;
            M_cnd   <= e_cnd;
            M_valE  <= e_valE;
            M_valA  <= e_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
            M_valid <= 1'b1;
        end
    end

    // Saturating event counters and sticky conflict flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
            ctl_err    <= 1'b0;
        end else begin
            if (M_bubble && (bubble_cnt != CNT_MAX))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (M_stall && !M_bubble && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (M_stall && M_bubble)
                ctl_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_mem_reg_p.sv
// Randomized bench for pipe_mem_reg_p: a default-width instance plus a
// 3-bit-counter instance sharing stimulus, both checked against a model.
module tb_pipe_mem_reg_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        M_stall, M_bubble;
    logic [3:0]  E_icode;
    logic [2:0]  E_stat;
    logic        e_cnd;
    logic [63:0] e_valE, e_valA;
    logic [3:0]  e_dstE, E_dstM;

    logic [3:0]  M_icode;
    logic [2:0]  M_stat;
    logic        M_cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_dstE, M_dstM;
    logic        M_valid;
    logic [15:0] bubble_cnt, stall_cnt;
    logic        ctl_err;

    logic [3:0]  s_icode;
    logic [2:0]  s_stat;
    logic        s_cnd;
    logic [63:0] s_valE, s_valA;
    logic [3:0]  s_dstE, s_dstM;
    logic        s_valid;
    logic [2:0]  s_bcnt, s_scnt;
    logic        s_err;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [3:0]  x_icode;
    logic [2:0]  x_stat;
    logic        x_cnd;
    logic [63:0] x_valE, x_valA;
    logic [3:0]  x_dstE, x_dstM;
    logic        x_valid;
    int          x_bcnt, x_scnt, x_bcnt_s, x_scnt_s;
    logic        x_err;

    pipe_mem_reg_p dut (
        .clk(clk), .rst(rst), .M_stall(M_stall), .M_bubble(M_bubble),
        .E_icode(E_icode), .E_stat(E_stat), .e_cnd(e_cnd),
        .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .E_dstM(E_dstM),
        .M_icode(M_icode), .M_stat(M_stat), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .M_valid(M_valid), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
        .ctl_err(ctl_err)
    );

    pipe_mem_reg_p #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .M_stall(M_stall), .M_bubble(M_bubble),
        .E_icode(E_icode), .E_stat(E_stat), .e_cnd(e_cnd),
        .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .E_dstM(E_dstM),
        .M_icode(s_icode), .M_stat(s_stat), .M_cnd(s_cnd),
        .M_valE(s_valE), .M_valA(s_valA), .M_dstE(s_dstE), .M_dstM(s_dstM),
        .M_valid(s_valid), .bubble_cnt(s_bcnt), .stall_cnt(s_scnt),
        .ctl_err(s_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        x_icode = 4'd1; x_stat = 3'd0; x_cnd = 1'b0;
        x_valE = '0; x_valA = '0; x_dstE = 4'd15; x_dstM = 4'd15;
        x_valid = 1'b0; x_err = 1'b0;
        x_bcnt = 0; x_scnt = 0; x_bcnt_s = 0; x_scnt_s = 0;
    endtask

    task automatic model_edge(input logic st, input logic bu);
        if (bu) begin
            x_icode = 4'd1; x_stat = 3'd0; x_cnd = 1'b0;
            x_valE = '0; x_valA = '0; x_dstE = 4'd15; x_dstM = 4'd15;
            x_valid = 1'b0;
            x_bcnt   = (x_bcnt   < 65535) ? x_bcnt + 1   : x_bcnt;
            x_bcnt_s = (x_bcnt_s < 7)     ? x_bcnt_s + 1 : x_bcnt_s;
            if (st) x_err = 1'b1;
        end else if (st) begin
            x_scnt   = (x_scnt   < 65535) ? x_scnt + 1   : x_scnt;
            x_scnt_s = (x_scnt_s < 7)     ? x_scnt_s + 1 : x_scnt_s;
        end else begin
            x_icode = E_icode; x_stat = E_stat; x_cnd = e_cnd;
            x_valE = e_valE; x_valA = e_valA; x_dstE = e_dstE; x_dstM = E_dstM;
            x_valid = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".icode"}, 64'(M_icode), 64'(x_icode));
        check({tag, ".stat"},  64'(M_stat),  64'(x_stat));
        check({tag, ".cnd"},   64'(M_cnd),   64'(x_cnd));
        check({tag, ".valE"},  M_valE, x_valE);
        check({tag, ".valA"},  M_valA, x_valA);
        check({tag, ".dstE"},  64'(M_dstE),  64'(x_dstE));
        check({tag, ".dstM"},  64'(M_dstM),  64'(x_dstM));
        check({tag, ".valid"}, 64'(M_valid), 64'(x_valid));
        check({tag, ".bcnt"},  64'(bubble_cnt), 64'(x_bcnt));
        check({tag, ".scnt"},  64'(stall_cnt),  64'(x_scnt));
        check({tag, ".err"},   64'(ctl_err),    64'(x_err));
        check({tag, ".bcnt3"}, 64'(s_bcnt), 64'(x_bcnt_s));
        check({tag, ".scnt3"}, 64'(s_scnt), 64'(x_scnt_s));
        check({tag, ".err3"},  64'(s_err),  64'(x_err));
    endtask

    task automatic rand_inputs();
        E_icode = 4'($urandom);
        E_stat  = 3'($urandom);
        e_cnd   = 1'($urandom);
        e_valE  = {$urandom, $urandom};
        e_valA  = {$urandom, $urandom};
        e_dstE  = 4'($urandom);
        E_dstM  = 4'($urandom);
    endtask

    // One clock edge with the given controls; checks 1 time unit after the edge
    task automatic cycle(input string tag, input logic st, input logic bu);
        M_stall = st; M_bubble = bu;
        @(posedge clk);
        model_edge(st, bu);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        M_stall = 1'b0; M_bubble = 1'b0;
        E_icode = '0; E_stat = '0; e_cnd = 1'b0;
        e_valE = '0; e_valA = '0; e_dstE = '0; E_dstM = '0;
        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // Directed load
        E_icode = 4'd3; E_stat = 3'd1; e_cnd = 1'b1;
        e_valE = 64'h1234; e_valA = 64'hABCD; e_dstE = 4'd2; E_dstM = 4'd15;
        cycle("load", 1'b0, 1'b0);
        check("load_valE", M_valE, 64'h1234);
        check("load_icode", 64'(M_icode), 64'd3);

        // Stall three edges with fresh inputs
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cycle("stall", 1'b1, 1'b0);
        end
        check("stall_cnt3", 64'(stall_cnt), 64'd3);
        check("stall_hold", M_valA, 64'hABCD);

        // Single bubble
        rand_inputs();
        cycle("bubble", 1'b0, 1'b1);
        check("bubble_cnt1", 64'(bubble_cnt), 64'd1);
        check("bubble_dstM", 64'(M_dstM), 64'd15);

        // Stall+bubble conflict, then normal loads
        rand_inputs();
        cycle("conflict", 1'b1, 1'b1);
        check("conflict_err", 64'(ctl_err), 64'd1);
        check("conflict_scnt", 64'(stall_cnt), 64'd3);
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            cycle("post_conf", 1'b0, 1'b0);
        end
        check("err_sticky", 64'(ctl_err), 64'd1);

        // Saturation of the 3-bit counter
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            cycle("sat", 1'b0, 1'b1);
            check("sat_bcnt3", 64'(s_bcnt), 64'((i + 1 < 7) ? i + 1 : 7));
        end

        // Asynchronous reset between edges
        rand_inputs();
        cycle("pre_async", 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_valid", 64'(M_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rand_inputs();
        cycle("post_rst", 1'b0, 1'b0);
        check("post_rst_valid", 64'(M_valid), 64'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rand_inputs();
            if (r < 2) do_reset();
            else if (r < 30) cycle("rnd", 1'b1, 1'b0);
            else if (r < 50) cycle("rnd", 1'b0, 1'b1);
            else if (r < 53) cycle("rnd", 1'b1, 1'b1);
            else cycle("rnd", 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
